// File: rtl/mips_pkg.sv
// Shared fetch-stage constants, opcode values and the fetch FSM state type.
// No logic; imported by the fetch unit and its IF/ID register.
package mips_pkg;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [5:0]  OP_J         = 6'h02;
  localparam logic [5:0]  OP_BEQ       = 6'h04;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: instr, PC+4 and valid; one-cycle capture on load.
// Holds when neither load nor flush; flush wins over load and inserts a NOP bubble.
module if_id_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        flush_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc4_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc4_o,
  output logic        valid_o
);
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (flush_i) begin
      // The bubble keeps the old PC+4; only instr and valid are cleared.
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (load_i) begin
      instr_d = instr_i;
      pc4_d   = pc4_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;
  assign valid_o = valid_q;
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, addresses instr_memory, fills IF/ID one clock after the PC is presented.
// stall_i holds PC and IF/ID; a jump/branch redirect overrides stall and costs one bubble.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          IMEM_AW  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [15:0] branch_off_i,
  input  logic        jump_i,
  input  logic [25:0] jump_tgt_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_instr_i,
  output logic [31:0] ifid_instr_o,
  output logic [31:0] ifid_pc4_o,
  output logic        ifid_valid_o
);
  localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};

  fetch_state_e state_q;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pc_plus4;
  logic         run, redirect, load, flush;

  assign pc_plus4 = pc_q + 32'd4;
  assign run      = (state_q == RUN);
  assign redirect = jump_i | branch_taken_i;
  assign flush    = run & redirect;
  assign load     = run & ~redirect & ~stall_i;

  always_comb begin
    pc_d = pc_q;
    // Redirect targets are relative to the instruction sitting in IF/ID, not to pc.
    if (flush && jump_i)
      pc_d = {ifid_pc4_o[31:28], jump_tgt_i, 2'b00};
    else if (flush)
      pc_d = ifid_pc4_o + {{14{branch_off_i[15]}}, branch_off_i, 2'b00};
    else if (load)
      pc_d = pc_plus4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC_AL;
    end else begin
      case (state_q)
        BOOT:    state_q <= RUN;
        default: begin
          state_q <= RUN;
          pc_q    <= pc_d;
        end
      endcase
    end
  end

  assign imem_addr_o = {{(32-IMEM_AW){1'b0}}, pc_q[IMEM_AW+1:2]};

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (load),
    .flush_i (flush),
    .instr_i (imem_instr_i),
    .pc4_i   (pc_plus4),
    .instr_o (ifid_instr_o),
    .pc4_o   (ifid_pc4_o),
    .valid_o (ifid_valid_o)
  );
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed fetch/stall/redirect/reset sequence plus a random phase, all checked against a reference model.
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i, branch_taken_i, jump_i;
  logic [15:0] branch_off_i;
  logic [25:0] jump_tgt_i;
  logic [31:0] imem_addr_o, imem_instr_i, ifid_instr_o, ifid_pc4_o;
  logic        ifid_valid_o;

  logic [31:0] mem [256];
  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_vld, m_boot;

  always #5 clk = ~clk;

  assign imem_instr_i = mem[imem_addr_o[7:0]];

  instr_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_i        (stall_i),
    .branch_taken_i (branch_taken_i),
    .branch_off_i   (branch_off_i),
    .jump_i         (jump_i),
    .jump_tgt_i     (jump_tgt_i),
    .imem_addr_o    (imem_addr_o),
    .imem_instr_i   (imem_instr_i),
    .ifid_instr_o   (ifid_instr_o),
    .ifid_pc4_o     (ifid_pc4_o),
    .ifid_valid_o   (ifid_valid_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_vld = 1'b0; m_boot = 1'b1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".addr"},  imem_addr_o, (m_pc / 4) % 256);
    chk({tag, ".instr"}, ifid_instr_o, m_instr);
    chk({tag, ".pc4"},   ifid_pc4_o, m_pc4);
    chk({tag, ".vld"},   {31'b0, ifid_valid_o}, {31'b0, m_vld});
  endtask

  // One clock: the model applies the priority rules with plain arithmetic, then both are compared.
  task automatic step(input string tag);
    logic [31:0] fetched;
    int signed   soff;
    fetched = mem[(m_pc / 4) % 256];
    soff    = int'($signed(branch_off_i));
    @(posedge clk); #1;
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (jump_i) begin
      m_pc = {m_pc4[31:28], jump_tgt_i, 2'b00};
      m_instr = 32'h0; m_vld = 1'b0;
    end else if (branch_taken_i) begin
      m_pc = m_pc4 + 32'(soff * 4);
      m_instr = 32'h0; m_vld = 1'b0;
    end else if (!stall_i) begin
      m_instr = fetched;
      m_pc4   = m_pc + 32'd4;
      m_pc    = m_pc + 32'd4;
      m_vld   = 1'b1;
    end
    chk_model(tag);
  endtask

  task automatic idle_inputs();
    stall_i = 0; branch_taken_i = 0; jump_i = 0; branch_off_i = '0; jump_tgt_i = '0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h8C010000; mem[1] = 32'h8C020004; mem[2] = 32'h00221820; mem[3] = 32'h00432022;
    mem[4] = 32'h8C030008; mem[5] = 32'h00642820; mem[6] = 32'h10620001; mem[7] = 32'h08000000;

    // Reset state
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #12;
    chk("rst.valid", {31'b0, ifid_valid_o}, 32'h0);
    chk("rst.instr", ifid_instr_o, 32'h0);
    chk("rst.pc4", ifid_pc4_o, 32'h0);
    chk("rst.addr", imem_addr_o, 32'h0);
    @(posedge clk); #1; rst_n = 1'b1;

    // BOOT cycle, then first fetch
    step("boot");
    chk("boot.addr", imem_addr_o, 32'h0);
    chk("boot.valid", {31'b0, ifid_valid_o}, 32'h0);
    step("f0");
    chk("f0.instr", ifid_instr_o, 32'h8C010000);
    chk("f0.pc4", ifid_pc4_o, 32'h4);
    chk("f0.valid", {31'b0, ifid_valid_o}, 32'h1);
    step("f1"); chk("f1.instr", ifid_instr_o, 32'h8C020004);
    step("f2"); chk("f2.instr", ifid_instr_o, 32'h00221820);

    // Stall 3 cycles
    stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      step("stall");
      chk("stall.instr", ifid_instr_o, 32'h00221820);
      chk("stall.addr", imem_addr_o, 32'h3);
    end
    stall_i = 0;
    step("unstall"); chk("unstall.instr", ifid_instr_o, 32'h00432022);
    step("f4");
    step("f5");
    step("f6");
    chk("f6.instr", ifid_instr_o, 32'h10620001);
    chk("f6.pc4", ifid_pc4_o, 32'h1C);

    // Taken branch, offset +1 word
    branch_taken_i = 1; branch_off_i = 16'h0001;
    step("br");
    chk("br.valid", {31'b0, ifid_valid_o}, 32'h0);
    chk("br.instr", ifid_instr_o, 32'h0);
    chk("br.addr", imem_addr_o, 32'h8);
    idle_inputs();
    step("br.tgt");
    chk("br.tgt.pc4", ifid_pc4_o, 32'h24);
    chk("br.tgt.instr", ifid_instr_o, mem[8]);

    // Mid-run asynchronous reset
    step("pre_rst");
    rst_n = 1'b0;
    #2;
    model_reset();
    chk("arst.valid", {31'b0, ifid_valid_o}, 32'h0);
    chk("arst.addr", imem_addr_o, 32'h0);
    chk_model("arst");
    @(posedge clk); #1; rst_n = 1'b1;
    step("reboot");
    chk("reboot.valid", {31'b0, ifid_valid_o}, 32'h0);
    step("refetch");
    chk("refetch.instr", ifid_instr_o, 32'h8C010000);
    for (int i = 0; i < 7; i++) step("run");
    chk("f7.instr", ifid_instr_o, 32'h08000000);
    chk("f7.pc4", ifid_pc4_o, 32'h20);

    // Jump together with stall: jump wins
    jump_i = 1; jump_tgt_i = 26'h0; stall_i = 1;
    step("jmp");
    chk("jmp.valid", {31'b0, ifid_valid_o}, 32'h0);
    chk("jmp.addr", imem_addr_o, 32'h0);
    idle_inputs();
    step("jmp.tgt");
    chk("jmp.tgt.instr", ifid_instr_o, 32'h8C010000);

    // Backward branch below zero wraps to 0xFFFFFFFC, then PC+4 wraps to 0
    branch_taken_i = 1; branch_off_i = 16'hFFFE; jump_i = 1'b0;
    step("wrap.br");
    chk("wrap.addr", imem_addr_o, 32'hFF);
    idle_inputs();
    step("wrap.fetch");
    chk("wrap.pc4", ifid_pc4_o, 32'h0);
    chk("wrap.instr", ifid_instr_o, mem[255]);

    // Random phase
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 11);
      jump_i         = (r == 0);
      branch_taken_i = (r == 1) || (r == 2) || (r == 0 && $urandom_range(0, 1) == 1);
      stall_i        = ($urandom_range(0, 3) == 0);
      branch_off_i   = 16'($urandom);
      jump_tgt_i     = 26'($urandom);
      if (i == 300) begin
        @(posedge clk); #1;
        rst_n = 1'b0; #2; model_reset();
        chk_model("rnd.arst");
        @(posedge clk); #1; rst_n = 1'b1;
      end
      step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
